match_result_ctrl: RTL and testbench
====================================

MATCH_RESULT_CTRL -- requirements
Module: match_result_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 5, points needed to win (1..15).
REQ-002 SHALL have parameter MATCH_SECONDS, default 60, match duration in seconds (1..127).
REQ-003 SHALL have parameter TICK_DIV, default 25000000, pixel-clock cycles per second.
REQ-004 SHALL have port clk_d  input  1  pixel clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  level from debounced start button; only the rising edge acts.
REQ-007 SHALL have port p1_point  input  1  one-cycle pulse, player 1 scored.
REQ-008 SHALL have port p2_point  input  1  one-cycle pulse, player 2 scored.
REQ-009 SHALL have port p1_score  output  4  player 1 score.
REQ-010 SHALL have port p2_score  output  4  player 2 score.
REQ-011 SHALL have port time_left  output  7  remaining seconds.
REQ-012 SHALL have port game_active  output  1  high in PLAY.
REQ-013 SHALL have port show_end  output  1  high in END; selects end screen.
REQ-014 SHALL have ports player1_win, player2_win, draw  output  1 each  match result to end-screen renderer.

Function
REQ-015 SHALL implement FSM IDLE, PLAY, END; all outputs registered.
REQ-016 SHALL detect start rising edge as start & ~start_q (start_q registered each cycle); held-high start SHALL not retrigger.
REQ-017 IDLE: start edge -> PLAY next cycle; p1_score=p2_score=0, time_left=MATCH_SECONDS, tick counter=0 on entry.
REQ-018 PLAY: each point pulse increments its score by 1, saturating at WIN_SCORE; p1_point and p2_point in the same cycle SHALL both count.
REQ-019 Tick counter SHALL count 0..TICK_DIV-1 in PLAY only, wrap to 0, and assert an internal sec_tick in the cycle it equals TICK_DIV-1.
REQ-020 sec_tick in PLAY SHALL decrement time_left by 1, never below 0.
REQ-021 PLAY -> END in the cycle after any score update makes a score equal WIN_SCORE, or after time_left becomes 0.
REQ-022 Result on END entry: only p1 at WIN_SCORE -> player1_win; only p2 at WIN_SCORE -> player2_win; both reach WIN_SCORE in the same cycle -> draw.
REQ-023 Timeout result: compare final scores; greater wins, equal -> draw; points arriving in the same cycle as the final sec_tick SHALL be counted before comparison.
REQ-024 Win score reached in the same cycle as timeout: the score rule of REQ-022 SHALL take precedence.
REQ-025 In END: exactly one of player1_win/player2_win/draw high, held stable; scores and time_left frozen; point pulses and ticks ignored.
REQ-026 Outside END: player1_win, player2_win, draw SHALL all be 0.
REQ-027 END: start edge -> PLAY with scores cleared, time_left reloaded, result flags cleared on the same edge.
REQ-028 PLAY: start edge SHALL be ignored (no restart mid-match).

Reset
REQ-029 reset SHALL override all other inputs, in any state, on the next clk_d edge.
REQ-030 Reset values: state IDLE, p1_score=0, p2_score=0, time_left=MATCH_SECONDS, game_active=0, show_end=0, all result flags 0, tick counter 0, start_q=1 (start held through reset does not trigger).

Structure
REQ-031 State encodings and the default WIN_SCORE/MATCH_SECONDS constants SHALL live in shared header pong_defs, reused by the score display and end screen.
REQ-032 The seconds divider SHALL be a sub-module sec_tick_gen (inputs clk_d, reset, enable; output sec_tick).

Verification (bench params TICK_DIV=4, MATCH_SECONDS=3, WIN_SCORE=3)
REQ-033 Reset, start edge, three p1_point pulses -> p1_score=3, next cycle show_end=1, player1_win=1, others 0.
REQ-034 Scores p1=2, p2=2, p1_point and p2_point in the same cycle -> both 3, END with draw=1.
REQ-035 p1=1, p2=0, no further points -> time_left 3,2,1,0 at 4-cycle spacing, then END with player1_win=1.
REQ-036 p1=1, p2=0, p2_point in the final sec_tick cycle -> END with draw=1.
REQ-037 In END, p1_point/p2_point/held start -> no change; start edge -> PLAY with scores 0, time_left=3, flags 0.
REQ-038 reset asserted mid-PLAY with p1=2 -> next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/pong_defs.sv
// Shared definitions for the pong match logic: game state encoding,
// default match constants and a small score helper. Also used by the
// score display and the end-screen renderer.
package pong_defs;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_END  = 2'd2
   } game_state_t;

   localparam int SCORE_W           = 4;
   localparam int TIME_W            = 7;
   localparam int DEF_WIN_SCORE     = 5;
   localparam int DEF_MATCH_SECONDS = 60;
   localparam int DEF_TICK_DIV      = 25000000;

   // Add one point unless the score already sits at the limit.
   function automatic logic [SCORE_W-1:0] sat_inc(
      input logic [SCORE_W-1:0] value,
      input logic               inc,
      input logic [SCORE_W-1:0] limit
   );
      if (inc && (value < limit))
         return value + 4'd1;
      return value;
   endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds divider: counts clock cycles while enabled and pulses sec_tick
// for one cycle every TICK_DIV cycles. The count is held at zero while
// disabled, so each enable period starts a fresh second.
module sec_tick_gen
   import pong_defs::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk_d,
   input  logic reset,
   input  logic enable,
   output logic sec_tick
);

   localparam int              CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_count;
   logic             w_at_last;

   assign w_at_last = (r_count == CNT_LAST);
   assign sec_tick  = enable & w_at_last;

   // Cycle counter: 0..TICK_DIV-1 while enabled, cleared otherwise.
   always_ff @(posedge clk_d) begin
      if (reset || !enable)
         r_count <= '0;
      else if (w_at_last)
         r_count <= '0;
      else
         r_count <= r_count + CNT_W'(1);
   end

endmodule

// File: rtl/match_result_ctrl.sv
// Match controller for pong: IDLE -> PLAY -> END. Keeps both scores and
// the countdown, decides the winner when a score reaches WIN_SCORE or the
// clock runs out, and drives registered flags for the end screen.
module match_result_ctrl
   import pong_defs::*;
#(
   parameter int WIN_SCORE     = DEF_WIN_SCORE,
   parameter int MATCH_SECONDS = DEF_MATCH_SECONDS,
   parameter int TICK_DIV      = DEF_TICK_DIV
) (
   input  logic                clk_d,
   input  logic                reset,
   input  logic                start,
   input  logic                p1_point,
   input  logic                p2_point,
   output logic [SCORE_W-1:0]  p1_score,
   output logic [SCORE_W-1:0]  p2_score,
   output logic [TIME_W-1:0]   time_left,
   output logic                game_active,
   output logic                show_end,
   output logic                player1_win,
   output logic                player2_win,
   output logic                draw
);

   localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
   localparam logic [TIME_W-1:0]  TIME_INIT = TIME_W'(MATCH_SECONDS);

   game_state_t        r_state, w_state_next;
   logic               r_start_q;
   logic [SCORE_W-1:0] r_p1_score, w_p1_next;
   logic [SCORE_W-1:0] r_p2_score, w_p2_next;
   logic [TIME_W-1:0]  r_time_left, w_time_next;
   logic               r_game_active, w_game_active_next;
   logic               r_show_end, w_show_end_next;
   logic               r_p1_win, w_p1_win_next;
   logic               r_p2_win, w_p2_win_next;
   logic               r_draw, w_draw_next;

   logic w_start_edge;
   logic w_sec_tick;
   logic w_p1_at_win;
   logic w_p2_at_win;

   assign w_start_edge = start & ~r_start_q;
   assign w_p1_at_win  = (r_p1_score == WIN_VAL);
   assign w_p2_at_win  = (r_p2_score == WIN_VAL);

   sec_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_sec_tick_gen (
      .clk_d    (clk_d),
      .reset    (reset),
      .enable   (r_state == ST_PLAY),
      .sec_tick (w_sec_tick)
   );

   // Next-state and next-output logic. The end decision is taken one cycle
   // after the registered score/time reaches its limit; scores and time are
   // frozen in that cycle so the result matches what is displayed.
   always_comb begin
      w_state_next  = r_state;
      w_p1_next     = r_p1_score;
      w_p2_next     = r_p2_score;
      w_time_next   = r_time_left;
      w_p1_win_next = 1'b0;
      w_p2_win_next = 1'b0;
      w_draw_next   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_start_edge) begin
               w_state_next = ST_PLAY;
               w_p1_next    = '0;
               w_p2_next    = '0;
               w_time_next  = TIME_INIT;
            end
         end
         ST_PLAY: begin
            if (w_p1_at_win || w_p2_at_win) begin
               // A winning score beats a simultaneous timeout.
               w_state_next  = ST_END;
               w_p1_win_next = w_p1_at_win & ~w_p2_at_win;
               w_p2_win_next = w_p2_at_win & ~w_p1_at_win;
               w_draw_next   = w_p1_at_win & w_p2_at_win;
            end else if (r_time_left == '0) begin
               w_state_next  = ST_END;
               w_p1_win_next = (r_p1_score > r_p2_score);
               w_p2_win_next = (r_p2_score > r_p1_score);
               w_draw_next   = (r_p1_score == r_p2_score);
            end else begin
               w_p1_next = sat_inc(r_p1_score, p1_point, WIN_VAL);
               w_p2_next = sat_inc(r_p2_score, p2_point, WIN_VAL);
               if (w_sec_tick)
                  w_time_next = r_time_left - TIME_W'(1);
            end
         end
         ST_END: begin
            if (w_start_edge) begin
               w_state_next = ST_PLAY;
               w_p1_next    = '0;
               w_p2_next    = '0;
               w_time_next  = TIME_INIT;
            end else begin
               w_p1_win_next = r_p1_win;
               w_p2_win_next = r_p2_win;
               w_draw_next   = r_draw;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      w_game_active_next = (w_state_next == ST_PLAY);
      w_show_end_next    = (w_state_next == ST_END);
   end

   // State and output registers; reset wins over every other input.
   always_ff @(posedge clk_d) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_start_q     <= 1'b1;
         r_p1_score    <= '0;
         r_p2_score    <= '0;
         r_time_left   <= TIME_INIT;
         r_game_active <= 1'b0;
         r_show_end    <= 1'b0;
         r_p1_win      <= 1'b0;
         r_p2_win      <= 1'b0;
         r_draw        <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_start_q     <= start;
         r_p1_score    <= w_p1_next;
         r_p2_score    <= w_p2_next;
         r_time_left   <= w_time_next;
         r_game_active <= w_game_active_next;
         r_show_end    <= w_show_end_next;
         r_p1_win      <= w_p1_win_next;
         r_p2_win      <= w_p2_win_next;
         r_draw        <= w_draw_next;
      end
   end

   assign p1_score    = r_p1_score;
   assign p2_score    = r_p2_score;
   assign time_left   = r_time_left;
   assign game_active = r_game_active;
   assign show_end    = r_show_end;
   assign player1_win = r_p1_win;
   assign player2_win = r_p2_win;
   assign draw        = r_draw;

endmodule

// File: tb/tb_match_result_ctrl.sv
// Bench for match_result_ctrl with WIN_SCORE=3, MATCH_SECONDS=3, TICK_DIV=4.
// Expected match results are queued when a match's stimulus is driven and
// compared when the end screen comes up.
module tb_match_result_ctrl;

   typedef struct packed {
      logic [3:0] p1;
      logic [3:0] p2;
      logic       w1;
      logic       w2;
      logic       d;
   } res_t;

   logic       clk_d = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       p1_point = 1'b0;
   logic       p2_point = 1'b0;
   logic [3:0] p1_score;
   logic [3:0] p2_score;
   logic [6:0] time_left;
   logic       game_active;
   logic       show_end;
   logic       player1_win;
   logic       player2_win;
   logic       draw;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];

   always #5 clk_d = ~clk_d;

   match_result_ctrl #(
      .WIN_SCORE     (3),
      .MATCH_SECONDS (3),
      .TICK_DIV      (4)
   ) dut (
      .clk_d       (clk_d),
      .reset       (reset),
      .start       (start),
      .p1_point    (p1_point),
      .p2_point    (p2_point),
      .p1_score    (p1_score),
      .p2_score    (p2_score),
      .time_left   (time_left),
      .game_active (game_active),
      .show_end    (show_end),
      .player1_win (player1_win),
      .player2_win (player2_win),
      .draw        (draw)
   );

   task automatic tick();
      @(posedge clk_d);
      #1;
   endtask

   function automatic res_t observed();
      return {p1_score, p2_score, player1_win, player2_win, draw};
   endfunction

   task automatic start_match();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Wait a bounded number of cycles for the end screen.
   task automatic wait_end(output bit ok);
      int n = 0;
      while (!show_end && n < 20) begin
         tick();
         n++;
      end
      ok = show_end;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      checks++;
      if ({p1_score, p2_score, time_left, game_active, show_end, player1_win, player2_win, draw}
          !== {4'd0, 4'd0, 7'd3, 5'b00000}) begin
         errors++;
         $display("FAIL reset_values: got p1=%0d p2=%0d t=%0d act=%b end=%b w=%b%b%b, want 0 0 3 0 0 000",
                  p1_score, p2_score, time_left, game_active, show_end, player1_win, player2_win, draw);
      end
      start = 1'b0;
      tick();
      checks++;
      if (game_active !== 1'b0) begin
         errors++;
         $display("FAIL held_start: game_active=%b, want 0", game_active);
      end
      $display("reset: done");
   endtask

   task automatic test_p1_win();
      res_t e, a;
      start_match();
      checks++;
      if ({game_active, show_end, p1_score, p2_score, time_left} !== {1'b1, 1'b0, 4'd0, 4'd0, 7'd3}) begin
         errors++;
         $display("FAIL start_play: act=%b end=%b p1=%0d p2=%0d t=%0d, want 1 0 0 0 3",
                  game_active, show_end, p1_score, p2_score, time_left);
      end
      exp_q.push_back({4'd3, 4'd0, 3'b100});
      p1_point = 1'b1;
      repeat (3) tick();
      checks++;
      if ({p1_score, show_end} !== {4'd3, 1'b0}) begin
         errors++;
         $display("FAIL p1_reach: p1=%0d end=%b, want 3 0", p1_score, show_end);
      end
      tick();  // extra point in the decision cycle must not exceed WIN_SCORE
      p1_point = 1'b0;
      checks++;
      if ({show_end, game_active} !== 2'b10) begin
         errors++;
         $display("FAIL p1_end_next: end=%b act=%b, want 1 0", show_end, game_active);
      end
      e = exp_q.pop_front();
      a = observed();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL p1_win_result: got %h, want %h", a, e);
      end
      $display("p1_win: result %h", a);
   endtask

   task automatic test_draw();
      res_t e, a;
      bit   ok;
      start_match();
      exp_q.push_back({4'd3, 4'd3, 3'b001});
      p1_point = 1'b1;
      p2_point = 1'b1;
      tick();
      tick();
      p1_point = 1'b0;
      p2_point = 1'b0;
      checks++;
      if ({p1_score, p2_score} !== {4'd2, 4'd2}) begin
         errors++;
         $display("FAIL draw_pre: p1=%0d p2=%0d, want 2 2", p1_score, p2_score);
      end
      p1_point = 1'b1;
      p2_point = 1'b1;
      tick();
      p1_point = 1'b0;
      p2_point = 1'b0;
      checks++;
      if ({p1_score, p2_score} !== {4'd3, 4'd3}) begin
         errors++;
         $display("FAIL draw_both: p1=%0d p2=%0d, want 3 3", p1_score, p2_score);
      end
      wait_end(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL draw_timeout: show_end=%b, want 1", show_end);
      end
      e = exp_q.pop_front();
      a = observed();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL draw_result: got %h, want %h", a, e);
      end
      $display("draw: result %h", a);
   endtask

   task automatic test_timeout();
      res_t e, a;
      logic [6:0] exp_t;
      start_match();
      exp_q.push_back({4'd1, 4'd0, 3'b100});
      p1_point = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         p1_point = 1'b0;
         exp_t = 7'(3 - k / 4);
         checks++;
         if (time_left !== exp_t) begin
            errors++;
            $display("FAIL timeout_count: cycle %0d time_left=%0d, want %0d", k, time_left, exp_t);
         end
      end
      checks++;
      if (show_end !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: show_end=%b at time 0, want 0", show_end);
      end
      tick();
      e = exp_q.pop_front();
      a = observed();
      checks++;
      if ({show_end, time_left, a} !== {1'b1, 7'd0, e}) begin
         errors++;
         $display("FAIL timeout_result: end=%b t=%0d res=%h, want 1 0 %h", show_end, time_left, a, e);
      end
      $display("timeout: result %h", a);
   endtask

   task automatic test_timeout_draw();
      res_t e, a;
      start_match();
      exp_q.push_back({4'd1, 4'd1, 3'b001});
      p1_point = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         p2_point = (k == 12);
         tick();
         p1_point = 1'b0;
         p2_point = 1'b0;
      end
      checks++;
      if ({time_left, p2_score, show_end} !== {7'd0, 4'd1, 1'b0}) begin
         errors++;
         $display("FAIL last_tick_point: t=%0d p2=%0d end=%b, want 0 1 0", time_left, p2_score, show_end);
      end
      tick();
      e = exp_q.pop_front();
      a = observed();
      checks++;
      if ({show_end, a} !== {1'b1, e}) begin
         errors++;
         $display("FAIL timeout_draw_result: end=%b res=%h, want 1 %h", show_end, a, e);
      end
      $display("timeout_draw: result %h", a);
   endtask

   task automatic test_end_hold();
      res_t e, a;
      start_match();
      exp_q.push_back({4'd0, 4'd3, 3'b010});
      p2_point = 1'b1;
      tick();
      p2_point = 1'b0;
      start = 1'b1;  // edge while playing: must be ignored
      tick();
      checks++;
      if ({game_active, show_end, p2_score, time_left} !== {1'b1, 1'b0, 4'd1, 7'd3}) begin
         errors++;
         $display("FAIL play_start_ignored: act=%b end=%b p2=%0d t=%0d, want 1 0 1 3",
                  game_active, show_end, p2_score, time_left);
      end
      p2_point = 1'b1;
      tick();
      tick();
      p2_point = 1'b0;
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({show_end, time_left, observed()} !== {1'b1, 7'd2, e}) begin
         errors++;
         $display("FAIL p2_win_result: end=%b t=%0d res=%h, want 1 2 %h", show_end, time_left, observed(), e);
      end
      p1_point = 1'b1;
      p2_point = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         a = observed();
         checks++;
         if ({show_end, time_left, a} !== {1'b1, 7'd2, e}) begin
            errors++;
            $display("FAIL end_frozen: cycle %0d end=%b t=%0d res=%h, want 1 2 %h", k, show_end, time_left, a, e);
         end
      end
      p1_point = 1'b0;
      p2_point = 1'b0;
      start = 1'b0;
      tick();
      start_match();
      checks++;
      if ({game_active, show_end, time_left, observed()} !== {1'b1, 1'b0, 7'd3, 11'd0}) begin
         errors++;
         $display("FAIL restart: act=%b end=%b t=%0d res=%h, want 1 0 3 000",
                  game_active, show_end, time_left, observed());
      end
      $display("end_hold: restart act=%b", game_active);
   endtask

   task automatic test_mid_reset();
      p1_point = 1'b1;
      tick();
      tick();
      p1_point = 1'b0;
      checks++;
      if ({p1_score, game_active} !== {4'd2, 1'b1}) begin
         errors++;
         $display("FAIL mid_pre: p1=%0d act=%b, want 2 1", p1_score, game_active);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({p1_score, p2_score, time_left, game_active, show_end, player1_win, player2_win, draw}
          !== {4'd0, 4'd0, 7'd3, 5'b00000}) begin
         errors++;
         $display("FAIL mid_reset: p1=%0d p2=%0d t=%0d act=%b end=%b w=%b%b%b, want 0 0 3 0 0 000",
                  p1_score, p2_score, time_left, game_active, show_end, player1_win, player2_win, draw);
      end
      tick();
      checks++;
      if (game_active !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_idle: act=%b, want 0", game_active);
      end
      $display("mid_reset: p1=%0d", p1_score);
   endtask

   initial begin
      test_reset();
      test_p1_win();
      test_draw();
      test_timeout();
      test_timeout_draw();
      test_end_hold();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
